// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Iteration counter width; one spare bit so WIDTH-1 always fits.
    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/restoring_divider_subtractor.sv
// N-bit ripple-borrow subtractor (o = i1 - i2 - bin); port order mirrors the ripple-carry adder.
module ripple_borrow_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic         bin,
    output logic [N-1:0] o,
    output logic         bout
);

    logic [N:0] w_borrow;

    assign w_borrow[0] = bin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            logic w_x;
            assign w_x             = i1[gi] ^ i2[gi];
            assign o[gi]           = w_x ^ w_borrow[gi];
            assign w_borrow[gi+1]  = (~i1[gi] & i2[gi]) | (~w_x & w_borrow[gi]);
        end
    endgenerate

    assign bout = w_borrow[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_r_sh;
    logic [WIDTH:0]   w_t;
    logic             w_bout;
    logic             w_accept;

    // R gets the MSB of Q shifted in; R's top bit is always 0 after a restore.
    assign w_r_sh   = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_FIN));

    ripple_borrow_subtractor #(.N(WIDTH + 1)) u_sub (
        .i1   (w_r_sh),
        .i2   ({1'b0, r_d}),
        .bin  (1'b0),
        .o    (w_t),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);

            if (w_accept) begin
                r_d     <= divisor;
                r_q     <= dividend;
                r_r     <= '0;
                r_cnt   <= '0;
                r_dz    <= (divisor == '0);
                r_busy  <= (divisor != '0);
                r_state <= (divisor == '0) ? S_FIN : S_CALC;
                if (r_state == S_IDLE && divisor != '0) begin
                    r_dbz <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_CALC: begin
                        r_r     <= w_bout ? w_r_sh : w_t;
                        r_q     <= {r_q[WIDTH-2:0], ~w_bout};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            r_state <= S_FIN;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // Results publish alongside done; a back-to-back accept reloads only the working regs.
            if (r_state == S_FIN) begin
                r_quot <= r_dz ? '1 : r_q;
                r_rem  <= r_dz ? r_q : r_r[WIDTH-1:0];
                r_dbz  <= r_dz;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider (WIDTH=4) with hand-computed expectations.
`timescale 1ns/100ps
module tb_restoring_divider;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges after the current accept edge until done is seen (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input int lat_exp, input logic [3:0] q_exp,
                          input logic [3:0] r_exp, input logic dz_exp);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        $display("[TB] %s: %0d/%0d -> q=%b r=%b dz=%0d latency=%0d", tag, a, b,
                 quotient, remainder, div_by_zero, lat);
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_quot"}, quotient, q_exp);
        check({tag, "_rem"}, remainder, r_exp);
        check({tag, "_dbz"}, div_by_zero, dz_exp);
        check({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int done_seen;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quot", quotient, 4'd0);
        check("rst_rem", remainder, 4'd0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div7_2", 4'd7, 4'd2, 5, 4'b0011, 4'b0001, 1'b0);
        run_op("div15_1", 4'd15, 4'd1, 5, 4'b1111, 4'b0000, 1'b0);
        run_op("div5_9", 4'd5, 4'd9, 5, 4'b0000, 4'b0101, 1'b0);
        run_op("div9_0", 4'd9, 4'd0, 1, 4'b1111, 4'b1001, 1'b1);
        run_op("div6_3", 4'd6, 4'd3, 5, 4'b0010, 4'b0000, 1'b0);

        // start held through CALC with changed operands, then accepted in FIN
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 4'd11;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        check("hold_busy_calc", busy, 1'b1);
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        $display("[TB] hold: 13/4 -> q=%b r=%b latency=%0d", quotient, remainder, lat);
        check("hold_latency", lat, 5);
        check("hold_quot", quotient, 4'b0011);
        check("hold_rem", remainder, 4'b0001);
        check("b2b_busy_no_gap", busy, 1'b1);
        wait_done(lat);
        $display("[TB] b2b: 11/2 -> q=%b r=%b latency=%0d", quotient, remainder, lat);
        check("b2b_latency", lat, 5);
        check("b2b_quot", quotient, 4'b0101);
        check("b2b_rem", remainder, 4'b0001);

        // Asynchronous reset mid-CALC aborts the operation
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #0.5;
        check("abort_busy", busy, 1'b0);
        check("abort_quot", quotient, 4'd0);
        check("abort_rem", remainder, 4'd0);
        check("abort_dbz", div_by_zero, 1'b0);
        #0.5;
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        $display("[TB] abort: 14/3 reset mid-CALC, done pulses afterwards=%0d", done_seen);
        check("abort_no_done", done_seen, 0);

        run_op("div12_4", 4'd12, 4'd4, 5, 4'b0011, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
